// File: rtl/canvas_reader_if.sv
// Port bundle for canvas_reader: scan control, RAM read port and pixel output stream.
// CANVAS_READER_CHECKSUM_EN adds the 16-bit checksum signal.
interface canvas_reader_if #(
    parameter int COLOR_W = 3
);
    logic               Start;
    logic [1:0]         aluOp;
    logic               Busy;
    logic               Done;
    logic               rdEn;
    logic [14:0]        rdAddr;
    logic [COLOR_W-1:0] rdData;
    logic [7:0]         outX;
    logic [6:0]         outY;
    logic [COLOR_W-1:0] outColour;
    // Stream handshake: a beat moves on a rising edge where outValid and outReady are both 1;
    // while outValid=1 and outReady=0 the head (outX, outY, outColour) is held unchanged.
    logic               outValid;
    logic               outReady;
    logic [1:0]         dbg_state;
`ifdef CANVAS_READER_CHECKSUM_EN
    logic [15:0]        checksum;
`endif

    modport master (
        input  Start, aluOp, rdData, outReady,
        output Busy, Done, rdEn, rdAddr, outX, outY, outColour, outValid, dbg_state
`ifdef CANVAS_READER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output Start, aluOp, rdData, outReady,
        input  Busy, Done, rdEn, rdAddr, outX, outY, outColour, outValid, dbg_state
`ifdef CANVAS_READER_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/canvas_reader.sv
// canvas_reader: raster read-back scanner over the 160x120 frame buffer with a 2-deep output FIFO.
// Optional feature macro: CANVAS_READER_CHECKSUM_EN (16-bit sum of streamed colours).
module canvas_reader #(
    parameter int COLOR_W = 3,
    parameter int ANS_X0  = 130,
    parameter int ANS_Y0  = 10
) (
    input logic             Clock,
    input logic             Reset,
    canvas_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic               busy_q;
    logic               done_q;
    logic [7:0]         x0;
    logic [7:0]         x_last;
    logic [7:0]         rx;
    logic [6:0]         y0;
    logic [6:0]         y_last;
    logic [6:0]         ry;
    logic               inflight;
    logic [7:0]         pipe_x;
    logic [6:0]         pipe_y;
    logic [7:0]         fifo_x [2];
    logic [6:0]         fifo_y [2];
    logic [COLOR_W-1:0] fifo_c [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         occ;
`ifdef CANVAS_READER_CHECKSUM_EN
    logic [15:0]        checksum_q;
`endif

    logic [7:0]         cur_x;
    logic [6:0]         cur_y;
    logic [14:0]        addr;
    logic [2:0]         pending;
    logic               pop;
    logic               issue;
    logic               last_pix;
    logic               drain_done;

    always_comb begin
        cur_x      = x0 + rx;
        cur_y      = y0 + ry;
        addr       = 15'(cur_y) * 15'd160 + 15'(cur_x);
        pop        = (occ != 2'd0) && bus.outReady;
        // Slots committed after this edge: stored entries plus the read in flight, less the pop.
        pending    = 3'(occ) + 3'(inflight) - 3'(pop);
        issue      = (state == READ) && (pending < 3'd2);
        last_pix   = (rx == x_last) && (ry == y_last);
        drain_done = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.rdEn      = issue;
    assign bus.rdAddr    = (state == READ) ? addr : 15'd0;
    assign bus.outValid  = (occ != 2'd0);
    assign bus.outX      = fifo_x[rd_ptr];
    assign bus.outY      = fifo_y[rd_ptr];
    assign bus.outColour = fifo_c[rd_ptr];
    assign bus.dbg_state = state;
`ifdef CANVAS_READER_CHECKSUM_EN
    assign bus.checksum  = checksum_q;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x0       <= 8'd0;
            y0       <= 7'd0;
            x_last   <= 8'd0;
            y_last   <= 7'd0;
            rx       <= 8'd0;
            ry       <= 7'd0;
            inflight <= 1'b0;
            pipe_x   <= 8'd0;
            pipe_y   <= 7'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_x[i] <= 8'd0;
                fifo_y[i] <= 7'd0;
                fifo_c[i] <= '0;
            end
`ifdef CANVAS_READER_CHECKSUM_EN
            checksum_q <= 16'd0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                pipe_x <= cur_x;
                pipe_y <= cur_y;
                if (rx == x_last) begin
                    rx <= 8'd0;
                    ry <= ry + 7'd1;
                end else begin
                    rx <= rx + 8'd1;
                end
            end
            // RAM data lands one cycle after rdEn, paired with the coordinates that travelled with it.
            if (inflight) begin
                fifo_x[wr_ptr] <= pipe_x;
                fifo_y[wr_ptr] <= pipe_y;
                fifo_c[wr_ptr] <= bus.rdData;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(inflight) - 2'(pop);
`ifdef CANVAS_READER_CHECKSUM_EN
            if (pop) begin
                checksum_q <= checksum_q + 16'(fifo_c[rd_ptr]);
            end
`endif

            case (state)
                IDLE: begin
                    if (bus.Start && (bus.aluOp != 2'b11)) begin
                        state  <= READ;
                        busy_q <= 1'b1;
                        rx     <= 8'd0;
                        ry     <= 7'd0;
                        case (bus.aluOp)
                            2'b00: begin
                                x0     <= 8'd0;
                                y0     <= 7'd0;
                                x_last <= 8'd159;
                                y_last <= 7'd119;
                            end
                            2'b01: begin
                                x0     <= 8'd0;
                                y0     <= 7'd0;
                                x_last <= 8'd114;
                                y_last <= 7'd119;
                            end
                            default: begin
                                x0     <= 8'(ANS_X0);
                                y0     <= 7'(ANS_Y0);
                                x_last <= 8'd20;
                                y_last <= 7'd20;
                            end
                        endcase
`ifdef CANVAS_READER_CHECKSUM_EN
                        checksum_q <= 16'd0;
`endif
                    end
                end
                READ: begin
                    if (issue && last_pix) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/canvas_reader.md
# canvas_reader

Read-back scanner for the 160x120 pixel frame buffer. On `Start` it walks a selected rectangular region (fullscreen, canvas or answer box) in raster order and issues one read address per pixel to a synchronous 1-cycle-latency RAM. It returns each pixel as an (x, y, colour) beat on a valid/ready stream. It is the reader counterpart of the pixel-coordinate counter that drives plotting into the same buffer, and it feeds answer-checking and compare logic.

## Interface
Parameters:
- `COLOR_W`, default 3: pixel colour width.
- `ANS_X0`, default 130: answer-box left edge, in pixels.
- `ANS_Y0`, default 10: answer-box top edge, in pixels.

Ports:
- `Clock`, in, 1: single clock; all logic is on its rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Start`, in, 1: begin a scan; sampled only in IDLE.
- `aluOp`, in, 2: region select, latched at Start. 00 = fullscreen, 01 = canvas, 10 = answer, 11 = reserved.
- `Busy`, out, 1: a scan is in progress.
- `Done`, out, 1: one-cycle pulse at scan completion.
- `rdEn`, out, 1: memory read strobe.
- `rdAddr`, out, 15: memory address, equal to y*160 + x.
- `rdData`, in, COLOR_W: memory data, valid the cycle after `rdEn`.
- `outX`, out, 8: pixel x coordinate, absolute.
- `outY`, out, 7: pixel y coordinate, absolute.
- `outColour`, out, COLOR_W: pixel colour.
- `outValid`, out, 1: stream valid.
- `outReady`, in, 1: stream ready.

## Operation
- Regions, as (x0, y0, width, height):
  - fullscreen: (0, 0, 160, 120).
  - canvas: (0, 0, 115, 120).
  - answer: (ANS_X0, ANS_Y0, 21, 21).
- FSM states:
  - IDLE -> READ on `Start` with `aluOp` != 11. `Start` with 11 is ignored: no Busy, no Done.
  - READ -> DRAIN after the last pixel's read is issued.
  - DRAIN -> DONE when the buffer is empty and nothing is in flight.
  - DONE -> IDLE after one cycle.
- Address counters:
  - Relative counters rx (0..width-1) and ry (0..height-1) advance only on a cycle with `rdEn`=1.
  - rx wraps to 0 and ry increments when rx = width-1.
  - rdAddr = (y0+ry)*160 + (x0+rx), computed at full width and truncated to 15 bits. The maximum value is 19199.
- Buffering:
  - 2-entry FIFO holds {x, y, colour}.
  - The x and y of an issued read travel with it through one pipeline register and are written into the FIFO alongside `rdData`.
- Issue rule: `rdEn`=1 in READ iff (FIFO occupancy + in-flight − pop this cycle) < 2. This gives one pixel per cycle when `outReady` is held high.
- Stream:
  - `outValid` = FIFO not empty. `outX`, `outY` and `outColour` show the FIFO head.
  - A beat transfers when `outValid` && `outReady`.
  - Head data holds stable while `outValid`=1 and `outReady`=0.
- `Start` while Busy is ignored. `aluOp` changes after Start have no effect on the current scan.
- Reset:
  - Outputs: FSM to IDLE; counters, FIFO and pipeline cleared; `Busy`=0, `Done`=0, `rdEn`=0, `outValid`=0, `rdAddr`=0, `outX`=0, `outY`=0, `outColour`=0.
  - A mid-scan reset aborts the scan with no Done pulse. Any in-flight `rdData` is discarded.

## Timing
- Start scan:
  - `Start` high in cycle 0.
  - Cycle 1: `Busy`=1, `rdEn`=1, `rdAddr` = first pixel.
  - Cycle 2: `rdData` is returned.
  - Cycle 3: `outValid`=1.
- Latency: `rdEn` to the matching `outValid` is 2 cycles when the FIFO is empty.
- Throughput: with `outReady`=1, one beat per cycle; N pixels end at cycle N+2.
- Completion: `Done` pulses in the cycle after the final beat's handshake. `Busy` is 0 in that same cycle and stays 0 afterwards.
- Back-to-back: a new `Start` is accepted in the cycle after `Done`.

## Configuration
- `CANVAS_READER_CHECKSUM_EN` defined:
  - Adds output `checksum` (16-bit).
  - Cleared at accepted Start.
  - Adds zero-extended `outColour` on every transferred beat, wrapping mod 2^16.
  - Valid and stable from the `Done` pulse until the next accepted Start.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Fullscreen scan with `outReady`=1, RAM content = addr[2:0]:
  - Expect 19200 beats, first (0, 0, 0), last (159, 119, 7).
  - `rdAddr` runs 0..19199 contiguously; `Done` is at cycle 19203.
- Answer region, ANS_X0=130, ANS_Y0=10:
  - Expect 441 beats; first rdAddr 1730 (x=130, y=10); last (150, 30) at rdAddr 4950.
  - Row wraps after x=150.
- Canvas scan with `outReady` toggled at random (about 30% high):
  - No lost or duplicated beats; head held stable while stalled.
  - FIFO never exceeds 2 entries; `rdEn` never violates the issue rule.
- Protocol misuse:
  - Start with `aluOp`=11: `Busy` stays 0 and no `Done`.
  - Start pulsed mid-scan: ignored; beat count unchanged.
  - `aluOp` changed mid-scan: no effect on the current scan.
- Reset asserted at beat 500 of a fullscreen scan:
  - All outputs at reset values the next cycle; no `Done`.
  - A following Start scans cleanly from (0, 0).
- Checksum (macro defined):
  - All-ones RAM (COLOR_W=3), fullscreen: `checksum` = 19200*7 mod 65536 = 3328 at `Done`.
  - Answer region: 441*7 = 3087.
